// File: rtl/branch_rs_pkg.sv
// Shared types and helpers for the branch reservation station and the ROB.
// Holds the micro-op payload, the default station depth and the ROB age function.
package branch_rs_pkg;

    localparam int BRANCH_RS_DEPTH = 8;
    localparam int PREG_W          = 7;
    localparam int ROB_W           = 5;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       imm;
        logic [6:0]        opcode;
        logic [2:0]        func3;
        logic [PREG_W-1:0] pd;
        logic [PREG_W-1:0] ps1;
        logic [PREG_W-1:0] ps2;
        logic [ROB_W-1:0]  rob_index;
    } rs_data;

    // Distance from the ROB head; wraps naturally at 2^ROB_W, smaller is older.
    function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] tag,
                                                 input logic [ROB_W-1:0] head);
        return tag - head;
    endfunction

endpackage

// File: rtl/rs_age_select.sv
// Combinational oldest-ready picker: returns the eligible entry with the smallest age.
module rs_age_select #(
    parameter int N     = 8,
    parameter int AGE_W = 5
) (
    input  logic [N-1:0]         eligible,
    input  logic [N*AGE_W-1:0]   ages,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_valid
);

    localparam int IDX_W = $clog2(N);

    logic [AGE_W-1:0] best_age;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred,
    // and use blocking assignments so the running minimum updates within one evaluation.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        best_age    = '0;
        for (int i = 0; i < N; i++) begin
            if (eligible[i] && (!grant_valid || ages[i*AGE_W +: AGE_W] < best_age)) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(i);
                best_age    = ages[i*AGE_W +: AGE_W];
            end
        end
    end

endmodule

// File: rtl/branch_rs.sv
// Branch reservation station: wakeup, oldest-ready select, registered issue, mispredict squash.
// Optional BRANCH_RS_WAKEUP_BYPASS_EN lets same-cycle wakeups count toward select readiness.
module branch_rs
    import branch_rs_pkg::*;
#(
    parameter int DEPTH    = BRANCH_RS_DEPTH,
    parameter int WB_PORTS = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       disp_valid,
    input  rs_data                     disp_data,
    input  logic                       disp_ps1_rdy,
    input  logic                       disp_ps2_rdy,
    output logic                       rs_b_ready,
    input  logic [WB_PORTS-1:0]        wb_valid,
    input  logic [WB_PORTS*PREG_W-1:0] wb_pd,
    input  logic                       fu_b_ready,
    input  logic [ROB_W-1:0]           rob_head,
    input  logic                       mispredict,
    input  logic [ROB_W-1:0]           mispredict_tag,
    output logic                       issued,
    output rs_data                     data_out,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] rdy1_q, rdy1_d;
    logic [DEPTH-1:0] rdy2_q, rdy2_d;
    rs_data           entry_q [DEPTH];
    rs_data           entry_d [DEPTH];
    logic             issued_q, issued_d;
    rs_data           data_out_q, data_out_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             rs_b_ready_q, rs_b_ready_d;

    logic [DEPTH-1:0]       wake1, wake2;
    logic                   disp_wake1, disp_wake2;
    logic [DEPTH-1:0]       rdy1_eff, rdy2_eff;
    logic [DEPTH-1:0]       eligible;
    logic [DEPTH-1:0]       younger;
    logic [DEPTH*ROB_W-1:0] ages;
    logic [ROB_W-1:0]       flush_age;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_valid;
    logic [IDX_W-1:0]       free_idx;
    logic                   disp_fire;
    logic                   issue_fire;

    // Wakeup matching for stored entries and for the incoming micro-op; preg 0 is always ready.
    always_comb begin
        wake1      = '0;
        wake2      = '0;
        disp_wake1 = (disp_data.ps1 == '0);
        disp_wake2 = (disp_data.ps2 == '0);
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = (entry_q[i].ps1 == '0);
            wake2[i] = (entry_q[i].ps2 == '0);
        end
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (wb_pd[p*PREG_W +: PREG_W] == entry_q[i].ps1) wake1[i] = 1'b1;
                    if (wb_pd[p*PREG_W +: PREG_W] == entry_q[i].ps2) wake2[i] = 1'b1;
                end
                if (wb_pd[p*PREG_W +: PREG_W] == disp_data.ps1) disp_wake1 = 1'b1;
                if (wb_pd[p*PREG_W +: PREG_W] == disp_data.ps2) disp_wake2 = 1'b1;
            end
        end
    end

    always_comb begin
`ifdef BRANCH_RS_WAKEUP_BYPASS_EN
        rdy1_eff = rdy1_q | wake1;
        rdy2_eff = rdy2_q | wake2;
`else
        rdy1_eff = rdy1_q;
        rdy2_eff = rdy2_q;
`endif
        eligible  = valid_q & rdy1_eff & rdy2_eff & {DEPTH{fu_b_ready}};
        flush_age = rob_age(mispredict_tag, rob_head);
        ages      = '0;
        younger   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ages[i*ROB_W +: ROB_W] = rob_age(entry_q[i].rob_index, rob_head);
            younger[i]             = rob_age(entry_q[i].rob_index, rob_head) > flush_age;
        end
    end

    rs_age_select #(
        .N     (DEPTH),
        .AGE_W (ROB_W)
    ) u_select (
        .eligible    (eligible),
        .ages        (ages),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Lowest free slot; the descending scan leaves the smallest index last.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    // Edge ordering: free the selected entry, then squash younger entries, then dispatch.
    always_comb begin
        valid_d    = valid_q;
        rdy1_d     = rdy1_q | wake1;
        rdy2_d     = rdy2_q | wake2;
        entry_d    = entry_q;
        issue_fire = grant_valid && !(mispredict && younger[grant_idx]);
        disp_fire  = disp_valid && rs_b_ready_q && !mispredict;

        if (grant_valid) valid_d[grant_idx] = 1'b0;
        if (mispredict)  valid_d = valid_d & ~younger;

        if (disp_fire) begin
            valid_d[free_idx] = 1'b1;
            rdy1_d[free_idx]  = disp_ps1_rdy | disp_wake1;
            rdy2_d[free_idx]  = disp_ps2_rdy | disp_wake2;
            entry_d[free_idx] = disp_data;
        end

        issued_d   = issue_fire;
        data_out_d = issue_fire ? entry_q[grant_idx] : data_out_q;

        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
        rs_b_ready_d = (occ_d < OCC_W'(DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= '0;
            rdy1_q       <= '0;
            rdy2_q       <= '0;
            issued_q     <= 1'b0;
            data_out_q   <= '0;
            occ_q        <= '0;
            rs_b_ready_q <= 1'b1;
        end else begin
            valid_q      <= valid_d;
            rdy1_q       <= rdy1_d;
            rdy2_q       <= rdy2_d;
            issued_q     <= issued_d;
            data_out_q   <= data_out_d;
            occ_q        <= occ_d;
            rs_b_ready_q <= rs_b_ready_d;
        end
    end

    // NOTE: the payload array has no reset; valid_q alone decides whether an entry means anything.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    assign rs_b_ready = rs_b_ready_q;
    assign issued     = issued_q;
    assign data_out   = data_out_q;
    assign occupancy  = occ_q;

endmodule
